// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int REG_BUS = 32;
  localparam logic [REG_BUS-1:0] PC_RSTN = 32'h0000_0000;
  localparam logic [REG_BUS-1:0] NOP_INSTR = 32'h0000_0013;

  // What happens to the memory response presented this cycle.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_KEEP,
    RSP_DROP
  } rspAction_e;

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fetch_sync_fifo.sv
// Small synchronous FIFO with registered storage, synchronous clear and an occupancy count.
module sync_fifo
  import if_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [cntWidth(DEPTH)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cntWidth(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear && !i_rst) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  // Clear behaves like reset; a simultaneous push or pop is discarded.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues imem reads under a credit limit, buffers in-order
// responses for decode and discards responses that belong to a flushed path.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int XLEN  = REG_BUS,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush_i,
  output logic            nop,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int CW = cntWidth(DEPTH);

  logic [CW-1:0]     w_inflight;
  logic [CW-1:0]     w_outCount;
  logic [CW:0]       w_used;
  logic              w_credit;
  logic              w_fire;
  rspAction_e        w_rspAct;
  logic              w_outPush;
  logic              w_outPop;
  logic [XLEN-1:0]   w_rspAddr;
  logic [2*XLEN-1:0] w_outHead;
  logic [CW-1:0]     r_discard;

  // Credit counts both outstanding reads and buffered words, so a full buffer stalls the PC.
  always_comb begin
    w_used   = {1'b0, w_inflight} + {1'b0, w_outCount};
    w_credit = w_used < (CW + 1)'(DEPTH);
    w_rspAct = RSP_NONE;
    if (imem_rsp_valid && !rst && (w_inflight != '0)) begin
      w_rspAct = (flush_i || (r_discard != '0)) ? RSP_DROP : RSP_KEEP;
    end
  end

  assign imem_req_valid = w_credit & ~flush_i & ~rst;
  assign imem_req_addr  = pc;
  assign w_fire         = imem_req_valid & imem_req_ready;
  assign nop            = rst | (~w_fire & ~flush_i);
  assign id_valid       = ~rst & (w_outCount != '0);
  assign w_outPush      = (w_rspAct == RSP_KEEP);
  assign w_outPop       = id_valid & id_ready;
  assign {id_pc, id_instr} = w_outHead;

  // On a flush every read still outstanding after this cycle belongs to the old path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_discard <= '0;
    end else if (flush_i) begin
      r_discard <= w_inflight - CW'(w_rspAct != RSP_NONE);
    end else if (w_rspAct == RSP_DROP) begin
      r_discard <= r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert (w_inflight != '0);
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addrFifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (1'b0),
    .i_push  (w_fire),
    .i_pop   (w_rspAct != RSP_NONE),
    .i_din   (pc),
    .o_dout  (w_rspAddr),
    .o_count (w_inflight)
  );

  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_outFifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (flush_i),
    .i_push  (w_outPush),
    .i_pop   (w_outPop),
    .i_din   ({w_rspAddr, imem_rsp_data}),
    .o_dout  (w_outHead),
    .o_count (w_outCount)
  );

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: consumer of the PC generator's `pc` and producer of its `nop` (hold) and `jump` inputs.
- Issues instruction-memory read requests at the current pc over a valid/ready request channel.
- Accepts in-order responses, buffers {pc, instr} pairs and presents them to decode over a valid/ready handshake.
- Tracks in-flight requests so a jump/flush discards stale responses.

Parameters:
- XLEN, 32, address/instruction width (matches `RegBus`).
- DEPTH, 2, max in-flight requests + buffered instructions (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc  in  XLEN  current fetch address from PC generator
- flush_i  in  1  redirect from execute, same cycle as PC generator `jump`
- nop  out  1  hold PC this cycle (to PC generator `nop`)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  read data valid, in request order, no backpressure
- imem_rsp_data  in  XLEN  instruction word
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts
- id_instr  out  XLEN  instruction
- id_pc  out  XLEN  address of id_instr

Behaviour:
- Reset (rst=1 at clk edge): inflight, discard and output-FIFO counts and pointers cleared. While rst=1: imem_req_valid=0, id_valid=0, nop=1.
- Credit: `credit = (inflight + out_count) < DEPTH`.
- Request:
  - imem_req_valid = credit & ~flush_i & ~rst; imem_req_addr = pc.
  - fire = imem_req_valid & imem_req_ready; on fire, push pc into the in-flight address FIFO and increment inflight.
- nop = ~fire & ~flush_i.
  - Never assert nop together with flush_i: the PC generator decodes jump&nop as reset.
  - PC advances (pc+4) exactly on cycles where fire=1.
- Response:
  - When imem_rsp_valid arrives: pop the in-flight address FIFO and decrement inflight.
  - If discard=0, write {addr, rsp_data} into the output FIFO; otherwise drop the response and decrement discard.
- Output: id_valid = out_count≠0; id_instr/id_pc from the FIFO head (registered storage). Pop on id_valid & id_ready.
- Latency: request fire at cycle T, response at T+k (k≥1), id_valid at T+k+1. No combinational rsp→id bypass.
- Flush (flush_i=1):
  - No request issued that cycle; output FIFO emptied at the edge.
  - discard ← inflight_after_this_cycle, i.e. current inflight + 0 (no fire) − (imem_rsp_valid ? 1 : 0) + existing discard handled consistently, so every pre-flush response is dropped.
  - A response arriving in the flush cycle is dropped.
  - A decode handshake completing in the flush cycle counts as delivered; killing it is decode's job.
  - Next cycle fetches the jump_addr now presented on pc.
- Simultaneous events:
  - Response arrival and decode pop in the same cycle: out_count unchanged.
  - Fire and response in the same cycle: inflight unchanged.
- Full: credit=0 ⇒ imem_req_valid=0, nop=1 (PC holds) until decode pops or a flush occurs.
- Counters never exceed DEPTH; a response with inflight=0 is a protocol error (assertion, no state change).
- Mid-operation reset: all in-flight responses are forgotten. The memory must be reset in the same cycle.

Decomposition:
- Shared defines (existing defines file): `RegBus` width, `pc_rstn` reset vector, NOP_INSTR 32'h00000013 for decode bubble use.
- One sub-module `sync_fifo` (parameter WIDTH, DEPTH; push/pop/clear/count), used twice:
  - in-flight address FIFO, WIDTH=XLEN;
  - output FIFO, WIDTH=2·XLEN.
- if_fetch holds credit, discard and flush logic only.

Test Plan:
- Streaming: pc=0x0,0x4,0x8…, memory ready=1, k=1, id_ready=1 → id_pc 0x0,0x4,0x8 on consecutive cycles starting 2 cycles after the first fire; nop=0 throughout.
- Backpressure: id_ready=0 with DEPTH=2 → exactly 2 requests (0x0,0x4) fire, then imem_req_valid=0, nop=1. Raising id_ready → 0x0 then 0x4 delivered, fetch resumes at 0x8.
- Memory stall: imem_req_ready=0 for 3 cycles → imem_req_valid=1, nop=1 every cycle, pc held at 0x10. Fire on the 4th cycle.
- Flush with 2 in flight (0x20,0x24): flush_i=1 and pc→0x100 → nop=0 in the flush cycle. Both late responses dropped; first id_pc after flush is 0x100.
- Flush coinciding with a response: the response is dropped, discard=1, the remaining stale response is dropped, and no id_valid before the 0x100 data.
- Reset mid-stream: rst=1 with 2 in flight and 1 buffered → next cycle id_valid=0, imem_req_valid=0. After rst deassert, first delivered id_pc = `pc_rstn`.
